// File: rtl/arm_pkg.sv
// Shared constants and types for the instruction fetch stage.
package arm_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetch buffer slot.
  typedef struct packed {
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous DEPTH-entry FIFO with push, pop, clear and occupancy.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;

  // Next pointer/occupancy; clear wins over any push or pop in the same cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en = push;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy is, so stale slots are never observed.
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential prefetch into a small buffer, redirect on PC departure.
module fetch_unit
  import arm_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        advance,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DROP_W = $clog2(2 * DEPTH) + 1;

  logic [31:0]       fetch_addr_q, fetch_addr_d;
  logic [31:0]       exp_addr_q, exp_addr_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W:0]    in_flight;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              redirect;
  logic              dropping;
  logic              accept;
  logic              resp_keep;
  logic              pop;

  // Any departure of the datapath PC from the sequential stream is a redirect.
  assign redirect  = (PC != exp_addr_q);
  assign dropping  = (drop_cnt_q != '0);
  assign in_flight = {1'b0, buf_count} + {1'b0, outstanding_q};

  assign imem_req  = ~reset & ~redirect & ~dropping & (in_flight < (CNT_W + 1)'(DEPTH));
  assign imem_addr = fetch_addr_q;
  assign accept    = imem_req & imem_gnt;

  // Responses belonging to a flushed stream are discarded, never buffered.
  assign resp_keep       = imem_rvalid & ~dropping & ~redirect;
  assign push_entry.data = imem_rdata;

  assign instr_valid = (buf_count != '0) & ~redirect;
  assign Instr       = head.data;
  assign pop         = instr_valid & advance;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (buf_count)
  );

  // Next fetch/expected address and request bookkeeping.
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    exp_addr_d    = exp_addr_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      // Everything still in flight now belongs to the abandoned stream.
      fetch_addr_d  = PC;
      exp_addr_d    = PC;
      outstanding_d = '0;
      drop_cnt_d    = drop_cnt_q + DROP_W'(outstanding_q) - DROP_W'(imem_rvalid);
    end else begin
      if (accept) fetch_addr_d = fetch_addr_q + 32'(WORD_BYTES);
      if (pop)    exp_addr_d   = exp_addr_q + 32'(WORD_BYTES);
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid & ~dropping);
      drop_cnt_d    = drop_cnt_q - DROP_W'(imem_rvalid & dropping);
    end
  end

  // Address and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr_q  <= RESET_PC;
      exp_addr_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      exp_addr_q    <= exp_addr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a behavioural memory and datapath model.
module tb_fetch_unit;
  import arm_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        advance;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .PC          (PC),
    .advance     (advance),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks   = 0;
  int          failures = 0;
  pend_t       pend[$];      // accepted requests awaiting a response, in order
  logic [31:0] exp_q[$];     // expected instruction words for the datapath, in retire order
  logic [31:0] seq_pc;       // next sequential address the stream should deliver
  logic [31:0] next_req;     // address the next fetch request must carry
  int          cyc;
  int          gnt_pct, adv_pct, jump_pct, lat_min, lat_max;
  int          retired;
  logic [31:0] watch_pc;
  bit          watch_hit;
  bit          lg_req[64];
  bit          lg_acc[64];
  bit          lg_iv[64];
  logic [31:0] lg_addr[64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // New datapath PC; a jump discards the expected stream, a retire extends it.
  task automatic set_pc(input logic [31:0] v, input bit jump);
    PC = v;
    if (jump) exp_q.delete();
    exp_q.push_back(mem_word(v));
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(2, 0))
      0:       t = PC + {24'd0, 6'($urandom_range(63, 0)), 2'b00};
      1:       t = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(3, 0)), 2'b00};
      default: t = $urandom & 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  // Drive memory and datapath inputs for the current cycle.
  task automatic drive();
    imem_gnt = ($urandom_range(99, 0) < gnt_pct);
    advance  = ($urandom_range(99, 0) < adv_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // One clock: sample at the falling edge, update models and drive just after the rising edge.
  task automatic step();
    logic        s_acc, s_rv, s_ret, s_redir;
    logic [31:0] s_addr;
    @(negedge clk);
    s_acc   = imem_req & imem_gnt;
    s_addr  = imem_addr;
    s_rv    = imem_rvalid;
    s_ret   = instr_valid & advance;
    s_redir = (PC != seq_pc);
    if (cyc < 64) begin
      lg_req[cyc]  = imem_req;
      lg_acc[cyc]  = s_acc;
      lg_iv[cyc]   = instr_valid;
      lg_addr[cyc] = imem_addr;
    end
    if (instr_valid && PC == watch_pc) watch_hit = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rv && pend.size() > 0) void'(pend.pop_front());
    if (s_acc) begin
      pend.push_back('{s_addr, cyc + int'($urandom_range(lat_max, lat_min)) - 1});
      next_req = next_req + 32'd4;
    end
    if (s_redir) begin
      seq_pc   = PC;
      next_req = PC;
    end else if (s_ret) begin
      seq_pc = seq_pc + 32'd4;
    end
    if (s_ret) begin
      retired++;
      set_pc(PC + 32'd4, 1'b0);
    end
    if (jump_pct > 0 && $urandom_range(99, 0) < jump_pct) set_pc(pick_target(), 1'b1);
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic config_bus(input int g, input int lmin, input int lmax, input int a, input int j);
    gnt_pct = g; lat_min = lmin; lat_max = lmax; adv_pct = a; jump_pct = j;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    advance     = 1'b0;
    pend.delete();
    seq_pc   = RPC;
    next_req = RPC;
    set_pc(RPC, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    drive();
  endtask

  // Monitor: compares every presented instruction and request against the models.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (imem_req) begin
        check("req_while_redirect", {31'd0, PC != seq_pc}, 32'd0);
        check("req_addr", imem_addr, next_req);
      end
      if (instr_valid) begin
        check("valid_while_redirect", {31'd0, PC != seq_pc}, 32'd0);
        if (exp_q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL instr_unexpected: got %h expected none", Instr);
        end else begin
          check("instr", Instr, exp_q[0]);
          if (advance) void'(exp_q.pop_front());
        end
      end
      if (pend.size() > DEPTH) check("outstanding_bound", pend.size(), DEPTH);
    end
  end

  initial begin
    config_bus(100, 1, 1, 100, 0);
    watch_pc  = 32'hDEAD_BEE0;
    watch_hit = 1'b0;
    retired   = 0;
    cyc       = 0;
    do_reset();
    check("reset_valid", instr_valid, 0);
    check("reset_instr", Instr, 0);

    // Streaming with single-cycle latency.
    run(6);
    for (int i = 0; i < 3; i++) begin
      check("t1_req", lg_req[i], 1);
      check("t1_addr", lg_addr[i], 32'(i * 4));
    end
    check("t1_iv0", lg_iv[0], 0);
    check("t1_iv1", lg_iv[1], 0);
    for (int i = 2; i < 6; i++) check("t1_iv_stream", lg_iv[i], 1);

    // Grant withheld: request held stable.
    config_bus(0, 1, 1, 100, 0);
    do_reset();
    run(3);
    for (int i = 0; i < 3; i++) begin
      check("t2_req_held", lg_req[i], 1);
      check("t2_addr_held", lg_addr[i], RPC);
      check("t2_no_valid", lg_iv[i], 0);
    end
    config_bus(100, 1, 1, 100, 0);
    run(10);

    // Stalled datapath fills the buffer then requests stop.
    config_bus(100, 1, 1, 0, 0);
    do_reset();
    run(10);
    begin
      int n_acc = 0;
      for (int i = 0; i < 10; i++) n_acc += int'(lg_acc[i]);
      check("t3_accepts", n_acc, DEPTH);
    end
    check("t3_req_stopped", lg_req[9], 0);
    adv_pct = 100;
    run(4);
    check("t3_req_resumes", {31'd0, lg_req[10] | lg_req[11] | lg_req[12] | lg_req[13]}, 1);
    run(8);

    // Redirect with two responses outstanding.
    config_bus(100, 4, 4, 0, 0);
    do_reset();
    run(2);
    set_pc(32'h0000_0040, 1'b1);
    watch_pc  = 32'h0000_0040;
    watch_hit = 1'b0;
    run(5);
    for (int i = 2; i < 6; i++) check("t4_req_dropping", lg_req[i], 0);
    adv_pct = 100;
    run(13);
    check("t4_req_after_drop", lg_req[6], 1);
    check("t4_addr_after_drop", lg_addr[6], 32'h0000_0040);
    check("t4_target_valid", watch_hit, 1);

    // Redirect near the top of the address space.
    config_bus(100, 1, 3, 100, 0);
    do_reset();
    run(3);
    set_pc(32'hFFFF_FFF8, 1'b1);
    watch_pc  = 32'h0000_0000;
    watch_hit = 1'b0;
    run(30);
    check("t5_wrap_valid", watch_hit, 1);

    // Asynchronous reset between edges mid-burst.
    config_bus(70, 1, 4, 80, 0);
    do_reset();
    run(20);
    #3;
    reset = 1'b1;
    #1;
    check("t6_valid_drop", instr_valid, 0);
    check("t6_req_drop", imem_req, 0);
    check("t6_instr_zero", Instr, 0);
    config_bus(100, 1, 1, 100, 0);
    do_reset();
    run(3);
    check("t6_restart_req", lg_req[0], 1);
    check("t6_restart_addr", lg_addr[0], RPC);
    check("t6_restart_iv", lg_iv[0], 0);

    // Randomized traffic with jumps and variable latency.
    do_reset();
    retired = 0;
    for (int blk = 0; blk < 15; blk++) begin
      int lmax;
      lmax = int'($urandom_range(6, 1));
      config_bus(int'($urandom_range(100, 20)), 1, lmax,
                 int'($urandom_range(100, 30)), int'($urandom_range(5, 0)));
      run(200);
    end
    check("random_progress", {31'd0, retired > 300}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
